sum_split: RTL and testbench

SUM_SPLIT -- requirements
Module: sum_split

---
 rtl/sum_split.sv | 79 +++++++
 tb/tb_sum_split.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_split.sv
// Recovers operand b from a registered (sum, a) pair: b = sum - a, with a
// 31-bit overflow flag. Two-stage valid/ready pipeline with a saturating overflow counter.
module sum_split #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_sum,
  input  logic [30:0]      in_a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [30:0]      out_b,
  output logic             out_ovf,
  output logic [CNT_W-1:0] ovf_cnt
);

  logic             r_s1_valid;
  logic [31:0]      r_s1_sum;
  logic [30:0]      r_s1_a;
  logic             r_s2_valid;
  logic [30:0]      r_out_b;
  logic             r_out_ovf;
  logic [CNT_W-1:0] r_ovf_cnt;

  logic        w_s2_adv;
  logic        w_in_fire;
  logic        w_out_fire;
  logic        w_cnt_max;
  logic [31:0] w_diff;

  // Stage 2 can take new data when it is empty or is being drained this cycle.
  assign w_s2_adv   = !r_s2_valid || out_ready;
  assign in_ready   = !reset && (!r_s1_valid || w_s2_adv);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_s2_valid && out_ready;
  assign w_cnt_max  = &r_ovf_cnt;
  assign w_diff     = r_s1_sum - {r_s1_a[30], r_s1_a};

  // NOTE: sequential state uses <= only, so every register samples pre-edge values
  // and the stage-1 to stage-2 hand-off needs no ordering tricks.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_sum   <= '0;
      r_s1_a     <= '0;
      r_s2_valid <= 1'b0;
      r_out_b    <= '0;
      r_out_ovf  <= 1'b0;
      r_ovf_cnt  <= '0;
    end else begin
      if (w_in_fire) begin
        r_s1_valid <= 1'b1;
        r_s1_sum   <= in_sum;
        r_s1_a     <= in_a;
      end else if (w_s2_adv) begin
        r_s1_valid <= 1'b0;
      end

      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_b   <= w_diff[30:0];
          r_out_ovf <= w_diff[31] ^ w_diff[30];
        end
      end

      if (w_out_fire && r_out_ovf && !w_cnt_max)
        r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
    end
  end

  assign out_valid = r_s2_valid;
  assign out_b     = r_out_b;
  assign out_ovf   = r_out_ovf;
  assign ovf_cnt   = r_ovf_cnt;

endmodule

// File: tb/tb_sum_split.sv
// Scoreboard bench for sum_split: driver pushes model results on accept,
// monitor pops and compares on every output transfer.
module tb_sum_split;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [30:0] b;
    logic        ovf;
  } exp_t;

  logic             clk       = 1'b0;
  logic             reset     = 1'b1;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [31:0]      in_sum    = '0;
  logic [30:0]      in_a      = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [30:0]      out_b;
  logic             out_ovf;
  logic [CNT_W-1:0] ovf_cnt;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  sum_split #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sum   (in_sum),
    .in_a     (in_a),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_b    (out_b),
    .out_ovf  (out_ovf),
    .ovf_cnt  (ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact signed difference taken modulo 2^32; overflow when that
  // 32-bit value lies outside the 31-bit signed range.
  function automatic exp_t model(input logic [31:0] s, input logic [30:0] a);
    exp_t   e;
    longint ds, da, w;
    ds = s[31] ? longint'(s) - (longint'(1) << 32) : longint'(s);
    da = a[30] ? longint'(a) - (longint'(1) << 31) : longint'(a);
    w  = (ds - da) & longint'(64'hFFFF_FFFF);
    if (w >= (longint'(1) << 31)) w = w - (longint'(1) << 32);
    e.ovf = (w > (longint'(1) << 30) - 1) || (w < -(longint'(1) << 30));
    e.b   = w[30:0];
    return e;
  endfunction

  task automatic drive(input logic rst, input logic v, input logic [31:0] s,
                       input logic [30:0] a, input logic ordy, output logic acc);
    @(negedge clk);
    reset     = rst;
    in_valid  = v;
    in_sum    = s;
    in_a      = a;
    out_ready = ordy;
    if (rst) sb.delete();
    #1;
    acc = v && in_ready;
    if (acc) sb.push_back(model(s, a));
  endtask

  task automatic send(input logic [31:0] s, input logic [30:0] a, input logic ordy);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      drive(1'b0, 1'b1, s, a, ordy, acc);
      n++;
    end
    if (!acc) check("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    logic acc;
    int   n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1, acc);
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  function automatic logic [31:0] pick_sum();
    logic [31:0] edges [6];
    edges = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h4000_0000, 32'hBFFF_FFFF};
    if ($urandom_range(0, 2) == 0) return edges[$urandom_range(0, 5)];
    return $urandom();
  endfunction

  function automatic logic [30:0] pick_a();
    logic [30:0] edges [4];
    edges = '{31'h0, 31'h7FFF_FFFF, 31'h4000_0000, 31'h3FFF_FFFF};
    if ($urandom_range(0, 2) == 0) return edges[$urandom_range(0, 3)];
    return 31'($urandom());
  endfunction

  task automatic random_phase(input int cycles);
    logic acc;
    for (int i = 0; i < cycles; i++)
      drive(1'b0, $urandom_range(0, 3) != 0, pick_sum(), pick_a(), $urandom_range(0, 3) != 0, acc);
  endtask

  // Monitor: samples after the driver has settled, ahead of the transfer edge.
  initial begin : monitor
    int          exp_cnt;
    logic        prev_stall;
    logic [30:0] prev_b;
    logic        prev_ovf;
    exp_t        e;
    exp_cnt    = 0;
    prev_stall = 1'b0;
    prev_b     = '0;
    prev_ovf   = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        exp_cnt    = 0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_b", 32'(out_b), 32'(prev_b));
          check("hold_ovf", 32'(out_ovf), 32'(prev_ovf));
        end
        if (out_valid && out_ready) begin
          check("ovf_cnt", 32'(ovf_cnt), 32'(exp_cnt));
          if (sb.size() == 0) begin
            check("unexpected_output", 32'(out_valid), 32'd0);
          end else begin
            e = sb.pop_front();
            check("out_b", 32'(out_b), 32'(e.b));
            check("out_ovf", 32'(out_ovf), 32'(e.ovf));
            if (e.ovf && exp_cnt < CNT_MAX) exp_cnt++;
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_b     = out_b;
        prev_ovf   = out_ovf;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic acc;
    int   n_acc;
    logic [31:0] cur;

    drive(1'b1, 1'b1, 32'h5, 31'h2, 1'b1, acc);
    drive(1'b1, 1'b1, 32'h5, 31'h2, 1'b1, acc);
    check("rst_in_ready_low", 32'(in_ready), 32'd0);
    drive(1'b0, 1'b0, '0, '0, 1'b1, acc);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    check("rst_out_b", 32'(out_b), 32'd0);
    check("rst_in_ready_high", 32'(in_ready), 32'd1);

    // Basic transfer and two-edge latency.
    drive(1'b0, 1'b1, 32'h0000_0005, 31'h2, 1'b1, acc);
    check("basic_accept", 32'(acc), 32'd1);
    drive(1'b0, 1'b0, '0, '0, 1'b1, acc);
    check("latency_not_yet", 32'(out_valid), 32'd0);
    drive(1'b0, 1'b0, '0, '0, 1'b1, acc);
    check("latency_valid", 32'(out_valid), 32'd1);
    check("basic_b", 32'(out_b), 32'h3);
    check("basic_ovf", 32'(out_ovf), 32'd0);
    drain();

    send(32'hFFFF_FFFF, 31'h7FFF_FFFF, 1'b1);
    send(32'hFFFF_FFFE, 31'h0000_0001, 1'b1);
    send(32'h4000_0000, 31'h0, 1'b1);
    drain();
    check("ovf_cnt_after_first_ovf", 32'(ovf_cnt), 32'd1);

    // Backpressure: only two pairs fit while downstream is stalled.
    n_acc = 0;
    cur   = 32'd1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, cur, 31'h0, 1'b0, acc);
      if (acc) begin
        n_acc++;
        cur++;
      end
    end
    check("bp_accepted", 32'(n_acc), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    drive(1'b0, 1'b1, 32'd3, 31'h0, 1'b1, acc);
    check("bp_release_accept", 32'(acc), 32'd1);
    check("bp_stream0", 32'(out_valid), 32'd1);
    drive(1'b0, 1'b0, '0, '0, 1'b1, acc);
    check("bp_stream1", 32'(out_valid), 32'd1);
    drive(1'b0, 1'b0, '0, '0, 1'b1, acc);
    check("bp_stream2", 32'(out_valid), 32'd1);
    drain();

    random_phase(400);
    drain();

    for (int i = 0; i < 260; i++) send(32'h4000_0000, 31'h0, 1'b1);
    drain();
    check("ovf_cnt_saturated", 32'(ovf_cnt), 32'(CNT_MAX));
    send(32'h4000_0000, 31'h0, 1'b1);
    drain();
    check("ovf_cnt_held", 32'(ovf_cnt), 32'(CNT_MAX));

    // Reset with both stages full.
    send(32'h4000_0000, 31'h0, 1'b0);
    send(32'h0000_0010, 31'h1, 1'b0);
    drive(1'b1, 1'b1, 32'h7, 31'h1, 1'b1, acc);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    drive(1'b0, 1'b0, '0, '0, 1'b1, acc);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    check("midrst_in_ready_high", 32'(in_ready), 32'd1);
    drive(1'b0, 1'b0, '0, '0, 1'b1, acc);
    check("midrst_no_stale", 32'(out_valid), 32'd0);

    random_phase(200);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
